// File: rtl/pwm_multi_timer.sv
// pwm_multi_timer: multi-channel PWM timer, one shared prescaled counter feeding per-channel comparators
// behind a 16-bit register port; PERIOD/DUTY are shadowed and reload at period boundaries.
module pwm_multi_timer #(
    parameter int CH_NUM  = 4,
    parameter int CNT_W   = 10,
    parameter int PRESC_W = 8,
    parameter int ADDR_W  = 4
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              acc_en_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [15:0]       wdata_i,
    output logic [15:0]       rdata_o,
    output logic [CH_NUM-1:0] pwm_o,
    output logic              irq_o
);
    logic               en_q, en_d, mode_q, mode_d, os_q, os_d, pev_q, pev_d, dir_q, dir_d;
    logic [CH_NUM-1:0]  oe_q, oe_d, pwm_q, pwm_d;
    logic [CNT_W-1:0]   per_sh_q, per_sh_d, per_q, per_d, cnt_q, cnt_d, last;
    logic [PRESC_W-1:0] presc_q, presc_d, psc_q, psc_d;
    logic [CNT_W-1:0]   duty_sh_q [CH_NUM];
    logic [CNT_W-1:0]   duty_sh_d [CH_NUM];
    logic [CNT_W-1:0]   duty_q [CH_NUM];
    logic [CNT_W-1:0]   duty_d [CH_NUM];
    logic [15:0]        rdata_q, rdata_d;
    logic               wr, rd, clr, tick, ev, load, unused;

    assign wr      = acc_en_i & wr_en_i;
    assign rd      = acc_en_i & ~wr_en_i;
    assign clr     = wr && addr_i == ADDR_W'(0) && wdata_i[2];
    assign tick    = en_q && psc_q == presc_q;
    assign last    = (per_q == '0) ? '0 : per_q - CNT_W'(1);
    // dir_q=1 is counting down; a center-aligned period ends on the tick leaving the held 0
    assign ev      = tick && !clr && (mode_q ? (dir_q && cnt_q == '0) : cnt_q >= last);
    assign load    = !en_q || ev;
    assign rdata_o = rdata_q;
    assign pwm_o   = pwm_q;
    assign irq_o   = pev_q;
    assign unused  = ^wdata_i;

    always_comb begin
        en_d      = en_q;
        mode_d    = mode_q;
        os_d      = os_q;
        oe_d      = oe_q;
        per_sh_d  = per_sh_q;
        presc_d   = presc_q;
        duty_sh_d = duty_sh_q;
        if (wr && addr_i == ADDR_W'(0)) begin
            en_d   = wdata_i[0];
            mode_d = wdata_i[1];
            os_d   = wdata_i[3];
            oe_d   = wdata_i[8 +: CH_NUM];
        end
        if (wr && addr_i == ADDR_W'(1)) per_sh_d = wdata_i[CNT_W-1:0];
        if (wr && addr_i == ADDR_W'(2)) presc_d = wdata_i[PRESC_W-1:0];
        for (int k = 0; k < CH_NUM; k++) begin
            if (wr && addr_i == ADDR_W'(4 + k)) duty_sh_d[k] = wdata_i[CNT_W-1:0];
            duty_d[k] = load ? duty_sh_q[k] : duty_q[k];
            pwm_d[k]  = en_q && oe_q[k] && cnt_q < duty_q[k];
        end
        if (ev && os_q) en_d = 1'b0;
        pev_d = ev || (pev_q && !(wr && addr_i == ADDR_W'(3) && wdata_i[1]));
        per_d = load ? per_sh_q : per_q;
        psc_d = (!en_q || clr || tick) ? '0 : psc_q + PRESC_W'(1);
        cnt_d = cnt_q;
        dir_d = mode_q && dir_q;
        if (!en_q || clr) begin
            cnt_d = '0;
            dir_d = 1'b0;
        end else if (tick) begin
            if (!mode_q) cnt_d = ev ? '0 : cnt_q + CNT_W'(1);
            else if (!dir_q && cnt_q >= last) dir_d = 1'b1;
            else if (dir_q && cnt_q == '0) dir_d = 1'b0;
            else cnt_d = dir_q ? cnt_q - CNT_W'(1) : cnt_q + CNT_W'(1);
        end
        rdata_d = rdata_q;
        if (rd) begin
            rdata_d = '0;
            if (addr_i == ADDR_W'(0)) rdata_d = {8'(oe_q), 4'b0, os_q, 1'b0, mode_q, en_q};
            if (addr_i == ADDR_W'(1)) rdata_d[CNT_W-1:0] = per_sh_q;
            if (addr_i == ADDR_W'(2)) rdata_d[PRESC_W-1:0] = presc_q;
            if (addr_i == ADDR_W'(3)) rdata_d[1:0] = {pev_q, en_q};
            for (int k = 0; k < CH_NUM; k++)
                if (addr_i == ADDR_W'(4 + k)) rdata_d[CNT_W-1:0] = duty_sh_q[k];
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            en_q     <= 1'b0;
            mode_q   <= 1'b0;
            os_q     <= 1'b0;
            pev_q    <= 1'b0;
            dir_q    <= 1'b0;
            oe_q     <= '0;
            pwm_q    <= '0;
            per_sh_q <= '0;
            per_q    <= '0;
            cnt_q    <= '0;
            presc_q  <= '0;
            psc_q    <= '0;
            rdata_q  <= '0;
            for (int k = 0; k < CH_NUM; k++) begin
                duty_sh_q[k] <= '0;
                duty_q[k]    <= '0;
            end
        end else begin
            en_q      <= en_d;
            mode_q    <= mode_d;
            os_q      <= os_d;
            pev_q     <= pev_d;
            dir_q     <= dir_d;
            oe_q      <= oe_d;
            pwm_q     <= pwm_d;
            per_sh_q  <= per_sh_d;
            per_q     <= per_d;
            cnt_q     <= cnt_d;
            presc_q   <= presc_d;
            psc_q     <= psc_d;
            rdata_q   <= rdata_d;
            duty_sh_q <= duty_sh_d;
            duty_q    <= duty_d;
        end
    end
endmodule

// File: tb/tb_pwm_multi_timer.sv
// tb_pwm_multi_timer: directed self-checking bench for pwm_multi_timer (default parameters).
module tb_pwm_multi_timer;
    logic        clk = 1'b0, rstn = 1'b0, acc_en = 1'b0, wr_en = 1'b0;
    logic [3:0]  addr = '0;
    logic [15:0] wdata = '0;
    logic [15:0] rdata;
    logic [3:0]  pwm;
    logic        irq;
    int          errors = 0, checks = 0;

    pwm_multi_timer dut (
        .clk_i(clk), .rstn_i(rstn), .acc_en_i(acc_en), .wr_en_i(wr_en), .addr_i(addr),
        .wdata_i(wdata), .rdata_o(rdata), .pwm_o(pwm), .irq_o(irq)
    );

    always #5 clk = ~clk;

    // bus write lands on the next rising edge; returns at the following falling edge
    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        acc_en = 1'b1; wr_en = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        acc_en = 1'b0; wr_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        acc_en = 1'b1; wr_en = 1'b0; addr = a;
        @(negedge clk);
        acc_en = 1'b0;
        d = rdata;
    endtask

    task automatic do_reset;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic test_reset;
        logic [15:0] d;
        rstn = 1'b0;
        #1;
        checks++; if (rdata !== 16'h0) begin errors++; $display("FAIL reset_rdata got=%h exp=0000", rdata); end
        checks++; if (pwm !== 4'h0) begin errors++; $display("FAIL reset_pwm got=%h exp=0", pwm); end
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got=%b exp=0", irq); end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int a = 0; a < 8; a++) begin
            rd(4'(a), d);
            checks++; if (d !== 16'h0) begin errors++; $display("FAIL reset_reg%0d got=%h exp=0000", a, d); end
        end
    endtask

    task automatic test_regs;
        logic [15:0] d;
        do_reset();
        wr(0, 16'hFF0E); rd(0, d);
        checks++; if (d !== 16'h0F0A) begin errors++; $display("FAIL reg_ctrl got=%h exp=0f0a", d); end
        wr(1, 16'hFFFF); rd(1, d);
        checks++; if (d !== 16'h03FF) begin errors++; $display("FAIL reg_period got=%h exp=03ff", d); end
        wr(2, 16'hFFFF); rd(2, d);
        checks++; if (d !== 16'h00FF) begin errors++; $display("FAIL reg_presc got=%h exp=00ff", d); end
        wr(7, 16'hABCD); rd(7, d);
        checks++; if (d !== 16'h03CD) begin errors++; $display("FAIL reg_duty3 got=%h exp=03cd", d); end
        wr(3, 16'hFFFF); rd(3, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reg_status got=%h exp=0000", d); end
        wr(8, 16'h1234); rd(8, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reg_unmapped8 got=%h exp=0000", d); end
        rd(0, d); rd(15, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL reg_unmapped15 got=%h exp=0000", d); end
        rd(0, d);
        @(negedge clk);
        wr(1, 16'h0000);
        checks++; if (rdata !== 16'h0F0A) begin errors++; $display("FAIL reg_rdata_hold got=%h exp=0f0a", rdata); end
    endtask

    task automatic test_edge;
        logic [31:0] exp;
        int first;
        do_reset();
        wr(2, 0); wr(1, 10); wr(4, 3); wr(0, 16'h0101);
        exp = 32'h0000_1C07;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            checks++; if (pwm[0] !== exp[i-1]) begin errors++; $display("FAIL edge_pwm0 clk=%0d got=%b exp=%b", i, pwm[0], exp[i-1]); end
            if (irq && first == 0) first = i;
        end
        checks++; if (first !== 10) begin errors++; $display("FAIL edge_pev_first got=%0d exp=10", first); end
        checks++; if (pwm[3:1] !== 3'b0) begin errors++; $display("FAIL edge_oe_off got=%b exp=000", pwm[3:1]); end
        wr(3, 16'h0002);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL edge_pev_clear got=%b exp=0", irq); end
        first = 0;
        for (int i = 22; i <= 30; i++) begin
            @(negedge clk);
            if (irq && first == 0) first = i;
        end
        checks++; if (first !== 30) begin errors++; $display("FAIL edge_pev_second got=%0d exp=30", first); end
    endtask

    task automatic test_center;
        logic [31:0] exp;
        int first, bad;
        do_reset();
        wr(2, 1); wr(1, 4); wr(5, 2); wr(0, 16'h0203);
        exp = 32'hF00F_F00F;
        first = 0; bad = 0;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            checks++; if (pwm[1] !== exp[i-1]) begin errors++; $display("FAIL center_pwm1 clk=%0d got=%b exp=%b", i, pwm[1], exp[i-1]); end
            if (pwm[0] !== 1'b0) bad++;
            if (irq && first == 0) first = i;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL center_pwm0 high_clocks=%0d exp=0", bad); end
        checks++; if (first !== 16) begin errors++; $display("FAIL center_pev_first got=%0d exp=16", first); end
    endtask

    task automatic test_shadow;
        logic [31:0] exp;
        do_reset();
        wr(2, 0); wr(1, 10); wr(4, 5); wr(0, 16'h0101);
        exp = 32'h0001_FC1F;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++; if (pwm[0] !== exp[i-1]) begin errors++; $display("FAIL shadow_pwm0 clk=%0d got=%b exp=%b", i, pwm[0], exp[i-1]); end
        end
        wr(4, 7);
        for (int i = 5; i <= 20; i++) begin
            @(negedge clk);
            checks++; if (pwm[0] !== exp[i-1]) begin errors++; $display("FAIL shadow_pwm0 clk=%0d got=%b exp=%b", i, pwm[0], exp[i-1]); end
        end
    endtask

    task automatic test_limits;
        int first, bad;
        do_reset();
        wr(2, 0); wr(1, 1000); wr(4, 0); wr(5, 1023); wr(0, 16'h0301);
        first = 0; bad = 0;
        for (int i = 1; i <= 1000; i++) begin
            @(negedge clk);
            if (pwm[1:0] !== 2'b10) bad++;
            if (irq && first == 0) first = i;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL limits_const bad_clocks=%0d exp=0", bad); end
        checks++; if (first !== 1000) begin errors++; $display("FAIL limits_pev_first got=%0d exp=1000", first); end
        do_reset();
        wr(1, 0); wr(4, 1); wr(0, 16'h0101);
        first = 0; bad = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (pwm[0] !== 1'b1) bad++;
            if (irq && first == 0) first = i;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL period0_pwm0 low_clocks=%0d exp=0", bad); end
        checks++; if (first !== 1) begin errors++; $display("FAIL period0_pev_first got=%0d exp=1", first); end
    endtask

    task automatic test_oneshot;
        logic [31:0] exp;
        logic [15:0] d;
        int first;
        do_reset();
        wr(1, 6); wr(4, 2); wr(0, 16'h0109);
        exp = 32'h0000_0003;
        first = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            checks++; if (pwm[0] !== exp[i-1]) begin errors++; $display("FAIL oneshot_pwm0 clk=%0d got=%b exp=%b", i, pwm[0], exp[i-1]); end
            if (irq && first == 0) first = i;
        end
        checks++; if (first !== 6) begin errors++; $display("FAIL oneshot_pev_first got=%0d exp=6", first); end
        rd(0, d);
        checks++; if (d !== 16'h0108) begin errors++; $display("FAIL oneshot_ctrl got=%h exp=0108", d); end
        rd(3, d);
        checks++; if (d !== 16'h0002) begin errors++; $display("FAIL oneshot_status got=%h exp=0002", d); end
        wr(3, 16'h0001);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq_hold got=%b exp=1", irq); end
        wr(3, 16'h0002);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clear got=%b exp=0", irq); end
    endtask

    task automatic test_clr_async;
        logic [31:0] exp;
        logic [15:0] d;
        int first;
        do_reset();
        wr(2, 0); wr(1, 10); wr(4, 3); wr(0, 16'h0101);
        repeat (4) @(negedge clk);
        wr(0, 16'h0105);
        exp = 32'h0001_01C0;
        first = 0;
        for (int i = 6; i <= 16; i++) begin
            @(negedge clk);
            checks++; if (pwm[0] !== exp[i]) begin errors++; $display("FAIL clr_pwm0 clk=%0d got=%b exp=%b", i, pwm[0], exp[i]); end
            if (irq && first == 0) first = i;
        end
        checks++; if (first !== 15) begin errors++; $display("FAIL clr_mid_pev got=%0d exp=15", first); end
        wr(3, 16'h0002);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_status_clear got=%b exp=0", irq); end
        repeat (7) @(negedge clk);
        wr(0, 16'h0105);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL clr_beats_event got=%b exp=0", irq); end
        first = 0;
        for (int i = 26; i <= 35; i++) begin
            @(negedge clk);
            if (irq && first == 0) first = i;
        end
        checks++; if (first !== 35) begin errors++; $display("FAIL clr_event_pev got=%0d exp=35", first); end
        repeat (9) @(negedge clk);
        wr(3, 16'h0002);
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL pev_beats_clear got=%b exp=1", irq); end
        wr(3, 16'h0002);
        checks++; if (irq !== 1'b0) begin errors++; $display("FAIL pev_clear_after got=%b exp=0", irq); end
        rd(0, d);
        checks++; if (d !== 16'h0101) begin errors++; $display("FAIL run_ctrl got=%h exp=0101", d); end
        repeat (9) @(negedge clk);
        checks++; if ({pwm[0], irq, rdata} !== {2'b11, 16'h0101}) begin errors++; $display("FAIL pre_async pwm0/irq/rdata got=%b/%b/%h exp=1/1/0101", pwm[0], irq, rdata); end
        #2 rstn = 1'b0;
        #1;
        checks++; if ({pwm, irq, rdata} !== 21'h0) begin errors++; $display("FAIL async_reset pwm/irq/rdata got=%h/%b/%h exp=0/0/0000", pwm, irq, rdata); end
        @(negedge clk);
        rstn = 1'b1;
        rd(0, d);
        checks++; if (d !== 16'h0000) begin errors++; $display("FAIL async_ctrl_lost got=%h exp=0000", d); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_edge();
        test_center();
        test_shadow();
        test_limits();
        test_oneshot();
        test_clr_async();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
